// File: rtl/vn_collector_pkg.sv
// Shared constants, lane-index width helper and FIFO entry type for the VN output collector.
package vn_collector_pkg;

  localparam int unsigned VN_DATA_W     = 24;
  localparam int unsigned VN_NUM_SW     = 8;
  localparam int unsigned VN_FIFO_DEPTH = 16;
  localparam int unsigned VN_CNT_W      = 16;

  // Bits needed to address every lane (two lanes per adder switch)
  function automatic int unsigned lane_w(input int unsigned num_sw);
    return (num_sw < 1) ? 1 : $clog2(2 * num_sw);
  endfunction

  localparam int unsigned VN_LANE_W = lane_w(VN_NUM_SW);

  typedef struct packed {
    logic [VN_LANE_W-1:0] lane;
    logic [VN_DATA_W-1:0] data;
  } vn_entry_t;

endpackage

// File: rtl/vn_result_fifo.sv
// Show-ahead result FIFO: head entry is visible combinationally, zero while empty.
module vn_result_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vn_output_collector.sv
// Collects per-switch VN result lanes, serialises them lowest lane first into a
// result FIFO and drains {lane, value} pairs over a valid/ready handshake.
module vn_output_collector
  import vn_collector_pkg::*;
#(
  parameter int unsigned DATA_TYPE  = VN_DATA_W,
  parameter int unsigned NUM_SW     = VN_NUM_SW,
  parameter int unsigned FIFO_DEPTH = VN_FIFO_DEPTH,
  parameter int unsigned CNT_W      = VN_CNT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*DATA_TYPE*NUM_SW-1:0]     i_vn,
  input  logic [2*NUM_SW-1:0]               i_vn_valid,
  input  logic                              i_clear,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic [DATA_TYPE-1:0]              o_data,
  output logic [lane_w(NUM_SW)-1:0]         o_lane,
  output logic                              o_busy,
  output logic                              o_overflow,
  output logic [CNT_W-1:0]                  o_result_cnt
);

  localparam int unsigned NUM_LANES = 2 * NUM_SW;
  localparam int unsigned LANE_W    = lane_w(NUM_SW);
  localparam int unsigned ENTRY_W   = LANE_W + DATA_TYPE;

  logic [NUM_LANES-1:0] pending;
  logic [DATA_TYPE-1:0] stage [NUM_LANES];
  logic [LANE_W-1:0]    sel;
  logic                 sel_found;
  logic [NUM_LANES-1:0] push_mask;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_din;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Fixed-priority encoder: lowest pending lane wins
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (pending[i] && !sel_found) begin
        sel       = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign pop       = o_valid && i_ready;
  assign push      = (pending != '0) && (!fifo_full || pop);
  assign push_mask = push ? (NUM_LANES'(1) << sel) : '0;
  // New input fits once the last pending lane leaves in this very cycle
  assign accept    = ((pending & ~push_mask) == '0);
  assign fifo_din  = {sel, stage[sel]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      o_overflow   <= 1'b0;
      o_result_cnt <= '0;
    end else if (i_clear) begin
      pending      <= '0;
      o_overflow   <= 1'b0;
      o_result_cnt <= '0;
    end else begin
      if (accept) begin
        pending <= i_vn_valid;
      end else begin
        pending <= pending & ~push_mask;
        if (i_vn_valid != '0) begin
          o_overflow <= 1'b1;
        end
      end
      if (pop) begin
        o_result_cnt <= o_result_cnt + CNT_W'(1);
      end
    end
  end

  // Staged values only change for lanes flagged valid in an accepted input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        stage[i] <= '0;
      end
    end else if (!i_clear && accept) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (i_vn_valid[i]) begin
          stage[i] <= i_vn[i*DATA_TYPE +: DATA_TYPE];
        end
      end
    end
  end

  vn_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_valid           = !fifo_empty;
  assign {o_lane, o_data}  = fifo_dout;
  assign o_busy            = (pending != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_vn_output_collector.sv
// Directed self-checking bench for vn_output_collector (DATA_TYPE=24, NUM_SW=8, depth 16).
module tb_vn_output_collector;
  import vn_collector_pkg::*;

  localparam int unsigned DW  = 24;
  localparam int unsigned NSW = 8;
  localparam int unsigned NL  = 2 * NSW;
  localparam int unsigned VNW = 2 * DW * NSW;

  logic            clk;
  logic            rst;
  logic [VNW-1:0]  i_vn;
  logic [NL-1:0]   i_vn_valid;
  logic            i_clear;
  logic            i_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [3:0]      o_lane;
  logic            o_busy;
  logic            o_overflow;
  logic [15:0]     o_result_cnt;

  int checks = 0;
  int errors = 0;

  vn_output_collector #(
    .DATA_TYPE  (24),
    .NUM_SW     (8),
    .FIFO_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_vn         (i_vn),
    .i_vn_valid   (i_vn_valid),
    .i_clear      (i_clear),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_lane       (o_lane),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_result_cnt (o_result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] valid;
    logic [23:0] base;
    logic        ready;
    logic        e_valid;
    logic [3:0]  e_lane;
    logic [23:0] e_data;
    logic        e_busy;
    logic        e_ovf;
    logic [15:0] e_cnt;
  } vec_t;

  // k-th valid lane gets base+k; invalid lanes carry junk that must never surface
  function automatic logic [VNW-1:0] mk_vn(input logic [15:0] v, input logic [23:0] base);
    logic [VNW-1:0] r;
    logic [23:0]    k;
    r = '0;
    k = '0;
    for (int i = 0; i < int'(NL); i++) begin
      if (v[i]) begin
        r[i*DW +: DW] = base + k;
        k = k + 24'd1;
      end else begin
        r[i*DW +: DW] = 24'hFFFFFF;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, input logic [23:0] base, input logic rdy);
    i_vn_valid = v;
    i_vn       = mk_vn(v, base);
    i_ready    = rdy;
  endtask

  vec_t      vecs [14];
  vn_entry_t exp_q [$];
  vn_entry_t e;
  int        iter;

  initial begin
    rst        = 1'b0;
    i_clear    = 1'b0;
    drive(16'h0000, 24'h0, 1'b0);

    vecs[0]  = '{16'h0008, 24'h000ABC, 1'b1, 1'b0, 4'd0,  24'h0,      1'b1, 1'b0, 16'd0};
    vecs[1]  = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd3,  24'h000ABC, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{16'h0000, 24'h0,      1'b1, 1'b0, 4'd0,  24'h0,      1'b0, 1'b0, 16'd1};
    vecs[3]  = '{16'h8421, 24'h1,      1'b1, 1'b0, 4'd0,  24'h0,      1'b1, 1'b0, 16'd1};
    vecs[4]  = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd0,  24'h1,      1'b1, 1'b0, 16'd1};
    vecs[5]  = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd5,  24'h2,      1'b1, 1'b0, 16'd2};
    vecs[6]  = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd10, 24'h3,      1'b1, 1'b0, 16'd3};
    vecs[7]  = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd15, 24'h4,      1'b1, 1'b0, 16'd4};
    vecs[8]  = '{16'h0000, 24'h0,      1'b1, 1'b0, 4'd0,  24'h0,      1'b0, 1'b0, 16'd5};
    vecs[9]  = '{16'h0003, 24'h10,     1'b1, 1'b0, 4'd0,  24'h0,      1'b1, 1'b0, 16'd5};
    vecs[10] = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd0,  24'h10,     1'b1, 1'b0, 16'd5};
    vecs[11] = '{16'h0100, 24'h20,     1'b1, 1'b1, 4'd1,  24'h11,     1'b1, 1'b0, 16'd6};
    vecs[12] = '{16'h0000, 24'h0,      1'b1, 1'b1, 4'd8,  24'h20,     1'b1, 1'b0, 16'd7};
    vecs[13] = '{16'h0000, 24'h0,      1'b1, 1'b0, 4'd0,  24'h0,      1'b0, 1'b0, 16'd8};

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    chk("rst_cnt",   32'(o_result_cnt), 32'd0);
    chk("rst_data",  32'(o_data), 32'd0);
    chk("rst_lane",  32'(o_lane), 32'd0);
    rst = 1'b1;
    cyc();

    // Single lane, multi-lane ordering, back-to-back accept
    for (int n = 0; n < 14; n++) begin
      drive(vecs[n].valid, vecs[n].base, vecs[n].ready);
      cyc();
      chk($sformatf("vec%0d_valid", n), 32'(o_valid), 32'(vecs[n].e_valid));
      chk($sformatf("vec%0d_busy", n), 32'(o_busy), 32'(vecs[n].e_busy));
      chk($sformatf("vec%0d_ovf", n), 32'(o_overflow), 32'(vecs[n].e_ovf));
      chk($sformatf("vec%0d_cnt", n), 32'(o_result_cnt), 32'(vecs[n].e_cnt));
      if (vecs[n].e_valid) begin
        chk($sformatf("vec%0d_lane", n), 32'(o_lane), 32'(vecs[n].e_lane));
        chk($sformatf("vec%0d_data", n), 32'(o_data), 32'(vecs[n].e_data));
      end
    end

    // Overflow: second input arrives while 15 lanes still pending
    drive(16'hFFFF, 24'h100, 1'b0);
    cyc();
    drive(16'h0001, 24'h500, 1'b0);
    cyc();
    chk("ovf_set", 32'(o_overflow), 32'd1);
    drive(16'h0000, 24'h0, 1'b0);
    for (int k = 0; k < 20; k++) cyc();
    chk("ovf_full_valid", 32'(o_valid), 32'd1);
    chk("ovf_full_busy",  32'(o_busy), 32'd1);
    chk("ovf_full_cnt",   32'(o_result_cnt), 32'd8);
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovf_drain%0d_valid", k), 32'(o_valid), 32'd1);
      chk($sformatf("ovf_drain%0d_lane", k), 32'(o_lane), 32'(k));
      chk($sformatf("ovf_drain%0d_data", k), 32'(o_data), 32'h100 + 32'(k));
      cyc();
    end
    chk("ovf_end_valid", 32'(o_valid), 32'd0);
    chk("ovf_end_busy",  32'(o_busy), 32'd0);
    chk("ovf_end_sticky", 32'(o_overflow), 32'd1);
    chk("ovf_end_cnt",   32'(o_result_cnt), 32'd24);

    // Backpressure: full FIFO plus 16 pending lanes, ready toggling
    drive(16'hFFFF, 24'h200, 1'b0);
    cyc();
    drive(16'h0000, 24'h0, 1'b0);
    for (int k = 0; k < 18; k++) cyc();
    drive(16'hFFFF, 24'h300, 1'b0);
    cyc();
    drive(16'h0000, 24'h0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      e.lane = 4'(k); e.data = 24'h200 + 24'(k); exp_q.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      e.lane = 4'(k); e.data = 24'h300 + 24'(k); exp_q.push_back(e);
    end
    for (int k = 0; k < 3; k++) cyc();
    iter = 0;
    while (exp_q.size() != 0 && iter < 200) begin
      i_ready = iter[0];
      chk($sformatf("bp%0d_valid", iter), 32'(o_valid), 32'd1);
      chk($sformatf("bp%0d_lane", iter), 32'(o_lane), 32'(exp_q[0].lane));
      chk($sformatf("bp%0d_data", iter), 32'(o_data), 32'(exp_q[0].data));
      if (i_ready) void'(exp_q.pop_front());
      cyc();
      iter++;
    end
    chk("bp_left", 32'(exp_q.size()), 32'd0);
    i_ready = 1'b0;
    chk("bp_end_valid", 32'(o_valid), 32'd0);
    chk("bp_end_busy",  32'(o_busy), 32'd0);
    chk("bp_end_cnt",   32'(o_result_cnt), 32'd56);

    // Clear mid-drain with 5 entries queued and a valid input in the same cycle
    drive(16'h001F, 24'h400, 1'b0);
    cyc();
    drive(16'h0000, 24'h0, 1'b0);
    for (int k = 0; k < 7; k++) cyc();
    chk("clr_pre_valid", 32'(o_valid), 32'd1);
    chk("clr_pre_data",  32'(o_data), 32'h400);
    drive(16'hFFFF, 24'h700, 1'b1);
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    drive(16'h0000, 24'h0, 1'b0);
    chk("clr_valid", 32'(o_valid), 32'd0);
    chk("clr_busy",  32'(o_busy), 32'd0);
    chk("clr_cnt",   32'(o_result_cnt), 32'd0);
    chk("clr_ovf",   32'(o_overflow), 32'd0);
    for (int k = 0; k < 3; k++) cyc();
    chk("clr_post_valid", 32'(o_valid), 32'd0);
    chk("clr_post_busy",  32'(o_busy), 32'd0);
    chk("clr_post_ovf",   32'(o_overflow), 32'd0);

    // Asynchronous reset between edges while data is queued
    drive(16'h0003, 24'h600, 1'b0);
    cyc();
    drive(16'h0000, 24'h0, 1'b0);
    for (int k = 0; k < 3; k++) cyc();
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    chk("ar_pre_valid", 32'(o_valid), 32'd1);
    chk("ar_pre_lane",  32'(o_lane), 32'd1);
    chk("ar_pre_data",  32'(o_data), 32'h601);
    chk("ar_pre_cnt",   32'(o_result_cnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 32'(o_valid), 32'd0);
    chk("ar_data",  32'(o_data), 32'd0);
    chk("ar_lane",  32'(o_lane), 32'd0);
    chk("ar_busy",  32'(o_busy), 32'd0);
    chk("ar_cnt",   32'(o_result_cnt), 32'd0);
    chk("ar_ovf",   32'(o_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("ar_post_valid", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vn_output_collector.md
Name: vn_output_collector

Overview:
- Receiving end of the adder-switch VN output interface.
- Captures the per-switch VN result lanes (2 lanes per adder switch, each with a valid bit) from every adder switch in the reduction network.
- Serialises those lanes, lowest lane first, into a result FIFO.
- Drains the FIFO one {lane index, value} pair per cycle over a valid/ready handshake toward the output buffer.

Parameters:
- DATA_TYPE, 24, width of one VN value.
- NUM_SW, 8, number of adder switches feeding the collector. Lanes L = 2*NUM_SW.
- FIFO_DEPTH, 16, result FIFO entries (power of 2, >= 2).
- CNT_W, 16, width of the result counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- i_vn  input  2*DATA_TYPE*NUM_SW  switch k occupies bits [k*2*DATA_TYPE +: 2*DATA_TYPE]; lower half = lane 2k, upper half = lane 2k+1.
- i_vn_valid  input  2*NUM_SW  bit 2k+b is the valid for lane 2k+b (bit 0 lower, bit 1 upper per switch).
- i_clear  input  1  synchronous flush of all state.
- i_ready  input  1  downstream accepts the o_data/o_lane pair this cycle.
- o_valid  output  1  FIFO head is valid.
- o_data  output  DATA_TYPE  FIFO head value.
- o_lane  output  clog2(2*NUM_SW)  global lane index of the head value.
- o_busy  output  1  pending lanes or FIFO non-empty.
- o_overflow  output  1  sticky: valid input lanes were dropped.
- o_result_cnt  output  CNT_W  number of completed output handshakes, wraps.

Behaviour:
- Reset (rst=0, async): pending bitmap, staging data, FIFO pointers and count, o_overflow and o_result_cnt all clear to 0. o_valid=0, o_busy=0, o_data/o_lane=0.
- Staging register holds L data slots plus an L-bit pending bitmap.
- Push select: lowest set bit of pending, by fixed priority encoder.
- Push condition: push = (pending != 0) && (!fifo_full || pop). The pushed entry is {lane index, staged data}, and its pending bit clears at the edge.
- Pop condition: pop = o_valid && i_ready. Simultaneous push and pop on a full FIFO is legal, and occupancy is unchanged.
- Accept condition: accept = ((pending & ~push_mask) == 0). The staging register can take the new input in the same cycle its last pending lane is pushed.
- On accept:
  - pending <= i_vn_valid.
  - Staged data updates only for lanes whose valid bit is 1.
  - If i_vn_valid = 0, pending goes to 0.
- If accept=0 and i_vn_valid != 0: the input is dropped and o_overflow sets to 1 at the next edge. It is held until i_clear or reset.
- Latency:
  - Lanes valid at edge t are staged at t+1.
  - The first (lowest) lane enters the FIFO at t+2, and o_valid=1 in cycle t+2 if the FIFO was empty.
  - Each further pending lane follows one per cycle while the FIFO has space.
- FIFO is show-ahead: o_data/o_lane are driven combinationally from the head entry, with o_valid = (count != 0).
- Pointers wrap modulo FIFO_DEPTH. Full when count == FIFO_DEPTH.
- FIFO full with no pop: push stalls, pending holds, accept=0, and any new valid input causes overflow.
- o_result_cnt increments on each pop, wrapping from 2^CNT_W-1 to 0.
- o_busy = (pending != 0) || (count != 0). It is combinational.
- i_clear=1 (synchronous, priority over everything but reset):
  - pending, FIFO count and pointers, o_overflow and o_result_cnt go to 0.
  - Input valid in the same cycle is ignored and does not set overflow.
  - No pop is counted that cycle.
- Reset mid-drain: all state is lost immediately and o_valid drops asynchronously.

Decomposition:
- Package vn_collector_pkg:
  - lane-index width function clog2(2*NUM_SW).
  - FIFO entry typedef {lane, data}.
  - Default DATA_TYPE/NUM_SW constants shared with the adder-switch network top.
- One sub-module: vn_result_fifo, a synchronous show-ahead FIFO with push/pop/clear, count, full and async active-low reset.
- Priority encoder and staging stay inline.

Test Plan (DATA_TYPE=24, NUM_SW=8, FIFO_DEPTH=16):
- Single lane:
  - Stimulus: i_vn_valid=16'h0008, lane 3 value 24'h00_0ABC, i_ready=1.
  - Response: o_valid=1 two cycles later with o_lane=3, o_data=24'h000ABC; o_result_cnt=1; o_busy=0 afterwards.
- Multi-lane ordering:
  - Stimulus: i_vn_valid=16'h8421 with values 1,2,3,4, i_ready=1.
  - Response: outputs on 4 consecutive cycles, lanes 0,5,10,15, data 1,2,3,4.
- Back-to-back accept:
  - Stimulus: valid=16'h0003, then 16'h0100 exactly when lane 1 pushes.
  - Response: new input accepted, o_overflow=0, output lanes 0,1,8.
- Overflow:
  - Stimulus: valid=16'hFFFF then valid=16'h0001 on the next cycle, i_ready=0.
  - Response: the second input is dropped and o_overflow=1 sticky. The FIFO fills to 16, with lanes 0..15 drained in order once i_ready=1.
- Backpressure with full FIFO:
  - Stimulus: i_ready toggles 1/0 on a full FIFO with lanes still pending.
  - Response: push occurs only on pop cycles, order preserved, no entry lost or duplicated.
- Clear and reset:
  - Stimulus: i_clear mid-drain with 5 entries queued.
  - Response: o_valid=0, o_busy=0, o_result_cnt=0 and o_overflow=0 the next cycle.
  - Stimulus: rst=0 asserted between clock edges.
  - Response: outputs go to 0 immediately.
